// File: rtl/store_rmw_ctrl.sv
// Store read-modify-write controller.
// Accepts byte, halfword and word stores and turns each into memory strobes.
// A word store is a single write. A byte or halfword store reads the containing
// word, merges the new lane(s) into it and writes the word back. Misaligned or
// illegal requests are rejected without touching memory.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_valid/ready   request handshake (ready only in IDLE)
//   req_addr/data     byte address, right-justified store data
//   req_size          00 byte, 01 half, 10 word, 11 illegal
//   mem_addr          word-aligned memory address
//   mem_rd/mem_wr     read / write strobes, held until mem_ack
//   mem_wdata         write data (the merged word)
//   mem_rdata         read data, valid with mem_ack during a read
//   mem_ack           completes the current strobe
//   done/err          one-cycle completion pulse, err marks a rejected request
module store_rmw_ctrl #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    state_t state;
    state_t state_next;

    logic [ADDR_W-1:2] addr_q;
    logic [1:0]        lane_q;
    logic              is_byte_q;
    logic [15:0]       data_q;
    logic [31:0]       mdr;
    logic              rd_q;
    logic              wr_q;
    logic              done_q;
    logic              err_q;

    logic              accept_c;
    logic              bad_c;
    logic [31:0]       merged_c;

    assign accept_c = (state == IDLE) && req_valid;

    // Alignment / legality check on the live request
    always_comb begin
        bad_c = 1'b0;
        case (req_size)
            SIZE_BYTE: bad_c = 1'b0;
            SIZE_HALF: bad_c = req_addr[0];
            SIZE_WORD: bad_c = (req_addr[1:0] != 2'b00);
            default:   bad_c = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (bad_c) begin
                        state_next = FIN;
                    end else if (req_size == SIZE_WORD) begin
                        state_next = WRITE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ: begin
                if (mem_ack) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Strobes and completion flags registered from the next state.
    // Only a rejected request goes straight from IDLE to FIN, which marks err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            rd_q   <= (state_next == READ);
            wr_q   <= (state_next == WRITE);
            done_q <= (state_next == FIN);
            err_q  <= (state_next == FIN) && (state == IDLE);
        end
    end

    // Lane merge of the stored data into the word read back from memory
    always_comb begin
        merged_c = mem_rdata;
        if (is_byte_q) begin
            case (lane_q)
                2'd0:    merged_c[7:0]   = data_q[7:0];
                2'd1:    merged_c[15:8]  = data_q[7:0];
                2'd2:    merged_c[23:16] = data_q[7:0];
                default: merged_c[31:24] = data_q[7:0];
            endcase
        end else if (lane_q[1]) begin
            merged_c[31:16] = data_q;
        end else begin
            merged_c[15:0] = data_q;
        end
    end

    // Request capture and MDR
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            lane_q    <= 2'b00;
            is_byte_q <= 1'b0;
            data_q    <= 16'h0000;
            mdr       <= 32'h0000_0000;
        end else if (accept_c) begin
            addr_q    <= req_addr[ADDR_W-1:2];
            lane_q    <= req_addr[1:0];
            is_byte_q <= (req_size == SIZE_BYTE);
            data_q    <= req_data[15:0];
            if (req_size == SIZE_WORD) begin
                mdr <= req_data;
            end
        end else if ((state == READ) && mem_ack) begin
            mdr <= merged_c;
        end
    end

    // Ready is masked by rst so it reads low throughout reset and high on the
    // first cycle after release.
    assign req_ready = (state == IDLE) && !rst;
    assign mem_addr  = {addr_q, 2'b00};
    assign mem_wdata = mdr;
    assign mem_rd    = rd_q;
    assign mem_wr    = wr_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Directed and randomized bench for store_rmw_ctrl with a word memory model,
// an ack responder with programmable delay and a byte-wise reference model.
module tb_store_rmw_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [256];
    logic        resp_ack  = 1'b0;
    logic        force_ack = 1'b0;
    int          ack_delay = 0;
    int          ack_cnt   = 0;

    int          wr_count   = 0;
    int          rd_count   = 0;
    int          both_high  = 0;
    int          stab_err   = 0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;
    logic [31:0] last_rd_addr = '0;
    logic        prev_rd    = 1'b0;
    logic        prev_wr    = 1'b0;
    logic        prev_ack   = 1'b0;
    logic [31:0] prev_addr  = '0;
    logic [31:0] prev_wdata = '0;

    logic [7:0]  ref_b [1024];

    store_rmw_ctrl #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    assign mem_ack   = resp_ack | force_ack;
    assign mem_rdata = mem[mem_addr[9:2]];

    function automatic logic [31:0] pattern(input int i);
        if (i >= 192) return 32'h1122_3344 ^ (32'(i) * 32'h9E37_79B1);
        return 32'h1122_3344;
    endfunction

    // Memory model, strobe monitors and stability check
    always @(posedge clk) begin
        if (mem_rd && mem_wr) both_high++;
        if (!rst && (mem_rd || mem_wr) && (prev_rd || prev_wr) && !prev_ack &&
            (mem_rd == prev_rd) &&
            ((mem_addr != prev_addr) || (mem_wr && (mem_wdata != prev_wdata))))
            stab_err++;
        prev_rd    <= mem_rd;
        prev_wr    <= mem_wr;
        prev_ack   <= mem_ack;
        prev_addr  <= mem_addr;
        prev_wdata <= mem_wdata;
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= pattern(i);
        end else begin
            if (mem_wr && mem_ack) begin
                mem[mem_addr[9:2]] <= mem_wdata;
                wr_count++;
                last_wr_addr = mem_addr;
                last_wr_data = mem_wdata;
            end
            if (mem_rd && mem_ack) begin
                rd_count++;
                last_rd_addr = mem_addr;
            end
        end
    end

    // Ack responder: ack after ack_delay waiting cycles of a strobe
    always @(negedge clk) begin
        if (rst) begin
            resp_ack = 1'b0;
            ack_cnt  = 0;
        end else begin
            if (resp_ack) begin
                resp_ack = 1'b0;
                ack_cnt  = 0;
            end
            if (mem_rd || mem_wr) begin
                if (ack_cnt >= ack_delay) resp_ack = 1'b1;
                else ack_cnt++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request and measure cycles from accept to done
    task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                          output int lat, output logic e);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_size  = s;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_data  = 32'h5A5A_5A5A;
        req_size  = 2'b11;
        lat = -1;
        e   = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                e   = err;
                break;
            end
        end
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int          lat;
        logic        e;
        int          wr0;
        int          rd0;
        int          seen;
        int          a;
        int          sz;
        logic [31:0] d;
        logic [31:0] w;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_size  = 2'b00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rd_wr", {30'd0, mem_rd, mem_wr}, 32'd0);
        check("rst_done_err", {30'd0, done, err}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(req_ready), 32'd1);

        // Half store, upper lane
        ack_delay = 0;
        wr0 = wr_count; rd0 = rd_count;
        do_req(32'h102, 32'h0000_ABCD, 2'b01, lat, e);
        check("half_lat", 32'(lat), 32'd3);
        check("half_err", 32'(e), 32'd0);
        check("half_rd_addr", last_rd_addr, 32'h100);
        check("half_wdata", last_wr_data, 32'hABCD_3344);
        check("half_counts", 32'((rd_count - rd0) * 16 + (wr_count - wr0)), 32'h11);

        // Word store
        wr0 = wr_count; rd0 = rd_count;
        do_req(32'h100, 32'hDEAD_BEEF, 2'b10, lat, e);
        check("word_lat", 32'(lat), 32'd2);
        check("word_err", 32'(e), 32'd0);
        check("word_addr", last_wr_addr, 32'h100);
        check("word_wdata", last_wr_data, 32'hDEAD_BEEF);
        check("word_counts", 32'((rd_count - rd0) * 16 + (wr_count - wr0)), 32'h01);

        // Byte store, lane 3, slow memory
        ack_delay = 3;
        do_req(32'h203, 32'h0000_00EE, 2'b00, lat, e);
        check("byte3_lat", 32'(lat), 32'd9);
        check("byte3_addr", last_wr_addr, 32'h200);
        check("byte3_wdata", last_wr_data, 32'hEE22_3344);
        check("byte3_stable", 32'(stab_err), 32'd0);

        // Byte lane 1 and half lower lane on the updated word
        ack_delay = 0;
        do_req(32'h201, 32'hFFFF_FF55, 2'b00, lat, e);
        check("byte1_wdata", last_wr_data, 32'hEE22_5544);
        do_req(32'h200, 32'h1234_9876, 2'b01, lat, e);
        check("half0_wdata", last_wr_data, 32'hEE22_9876);
        check("half0_lat", 32'(lat), 32'd3);

        // Rejected requests
        wr0 = wr_count; rd0 = rd_count;
        do_req(32'h101, 32'h0000_1111, 2'b01, lat, e);
        check("mis_half_lat", 32'(lat), 32'd1);
        check("mis_half_err", 32'(e), 32'd1);
        do_req(32'h100, 32'h0000_2222, 2'b11, lat, e);
        check("ill_size_lat", 32'(lat), 32'd1);
        check("ill_size_err", 32'(e), 32'd1);
        do_req(32'h102, 32'h3333_3333, 2'b10, lat, e);
        check("mis_word_err", 32'({lat[7:0], 7'd0, e}), 32'h0000_0101);
        check("reject_no_strobe", 32'((rd_count - rd0) + (wr_count - wr0)), 32'd0);

        // Reset in the second WRITE cycle with ack pending
        ack_delay = 5;
        wr0 = wr_count;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h140;
        req_data  = 32'hCAFE_F00D;
        req_size  = 2'b10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_wr_before", 32'(mem_wr), 32'd1);
        #1;
        rst = 1'b1;
        force_ack = 1'b1;
        #1;
        check("abort_wr_drop", 32'(mem_wr), 32'd0);
        check("abort_no_done", 32'(done), 32'd0);
        check("abort_ready_low", 32'(req_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_ready_high", 32'(req_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done || mem_wr || mem_rd) seen++;
        end
        force_ack = 1'b0;
        check("abort_ack_ignored", 32'(seen), 32'd0);
        check("abort_no_write", 32'(wr_count - wr0), 32'd0);

        // Random stores against the byte-wise reference
        for (int i = 0; i < 1024; i++) begin
            w = pattern(i / 4);
            ref_b[i] = w[8 * (i % 4) +: 8];
        end
        for (int k = 0; k < 24; k++) begin
            ack_delay = $urandom_range(0, 2);
            sz = $urandom_range(0, 2);
            a  = 32'h300 + $urandom_range(0, 63);
            if (sz == 1) a = a & ~1;
            if (sz == 2) a = a & ~3;
            d = $urandom;
            do_req(32'(a), d, 2'(sz), lat, e);
            check("rand_done", 32'({lat > 0, e}), 32'h2);
            ref_b[a] = d[7:0];
            if (sz >= 1) ref_b[a + 1] = d[15:8];
            if (sz == 2) begin
                ref_b[a + 2] = d[23:16];
                ref_b[a + 3] = d[31:24];
            end
        end
        @(negedge clk);
        for (int i = 192; i < 208; i++) begin
            w = {ref_b[4 * i + 3], ref_b[4 * i + 2], ref_b[4 * i + 1], ref_b[4 * i]};
            check("rand_mem", mem[i], w);
        end
        check("rd_wr_exclusive", 32'(both_high), 32'd0);
        check("strobe_stable", 32'(stab_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/store_rmw_ctrl.md
STORE_RMW_CTRL -- requirements
Module: store_rmw_ctrl

Interface
REQ-001 The block SHALL have one parameter: ADDR_W, default 32, memory address width in bits.
REQ-002 Port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 Port req_valid, input, 1 bit: store request present.
REQ-005 Port req_ready, output, 1 bit: block can accept a request; high only in IDLE.
REQ-006 Port req_addr, input, ADDR_W bits: byte address of the store.
REQ-007 Port req_data, input, 32 bits: store data, right-justified (byte in [7:0], half in [15:0]).
REQ-008 Port req_size, input, 2 bits: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 Port mem_addr, output, ADDR_W bits: word-aligned memory address ({addr[ADDR_W-1:2],2'b00}).
REQ-010 Port mem_rd, output, 1 bit: memory read strobe.
REQ-011 Port mem_wr, output, 1 bit: memory write strobe.
REQ-012 Port mem_wdata, output, 32 bits: write data.
REQ-013 Port mem_rdata, input, 32 bits: read data, valid when mem_ack is high during a read.
REQ-014 Port mem_ack, input, 1 bit: memory completes the current strobe this cycle.
REQ-015 Port done, output, 1 bit: one-cycle pulse, store finished or rejected.
REQ-016 Port err, output, 1 bit: qualifies done; request rejected as misaligned or illegal.

Function
REQ-017 FSM states SHALL be IDLE, READ, WRITE, FIN.
REQ-018 In IDLE, req_valid high SHALL accept the request; addr, data and size are registered; the request inputs are ignored outside the accept cycle.
REQ-019 Accepted requests SHALL be checked: size 11, half with addr[0]=1, or word with addr[1:0]!=00 go IDLE->FIN with err set and no memory strobe.
REQ-020 Valid word stores SHALL go IDLE->WRITE; valid byte/half stores SHALL go IDLE->READ.
REQ-021 READ SHALL hold mem_rd=1 and mem_addr stable until mem_ack; on the ack cycle the merged word is captured into the internal MDR register and the FSM moves to WRITE.
REQ-022 Half merge: addr[1]=0 gives {rdata[31:16], data[15:0]}; addr[1]=1 gives {data[15:0], rdata[15:0]}.
REQ-023 Byte merge: lane addr[1:0] replaced by data[7:0] (lane 0 = bits [7:0], lane 3 = bits [31:24]); other lanes keep rdata.
REQ-024 Word store: MDR SHALL be loaded with req_data at accept.
REQ-025 WRITE SHALL hold mem_wr=1, mem_wdata=MDR and mem_addr stable until mem_ack, then move to FIN.
REQ-026 FIN SHALL assert done=1 for exactly one cycle (err=1 only for rejected requests) and return to IDLE.
REQ-027 mem_rd and mem_wr SHALL never be high in the same cycle; both low in IDLE and FIN.
REQ-028 mem_ack while in IDLE or FIN SHALL be ignored.
REQ-029 Latency with mem_ack in the first strobe cycle: word store done 2 cycles after accept; byte/half store 3 cycles; rejected request 1 cycle.
REQ-030 A new request SHALL NOT be accepted in the FIN cycle; back-to-back requests are spaced by at least one IDLE cycle.

Reset
REQ-031 On rst high the block SHALL asynchronously enter IDLE with mem_rd=0, mem_wr=0, done=0, err=0, req_ready=0 while rst is high; mem_addr, mem_wdata and MDR reset to 0.
REQ-032 On rst release req_ready SHALL be 1 in the first cycle.
REQ-033 Reset during READ or WRITE SHALL abort the store without a done pulse; an in-flight mem_ack after reset is ignored.

Verification
REQ-034 Word store addr 0x100, data 0xDEADBEEF, ack immediate -> one write at 0x100 with 0xDEADBEEF, done 2 cycles after accept, err=0.
REQ-035 Half store addr 0x102, data 0x0000ABCD, mem_rdata 0x11223344 -> read 0x100, write 0xABCD3344, done at cycle 3.
REQ-036 Byte store addr 0x203, data 0x000000EE, mem_rdata 0x11223344, ack delayed 3 cycles on each strobe -> strobes held stable, write 0xEE223344 to 0x200.
REQ-037 Half store addr 0x101 or req_size 11 -> no mem_rd/mem_wr, done=1 and err=1 one cycle after accept.
REQ-038 rst asserted in the second WRITE cycle with ack pending -> mem_wr drops same cycle, no done, req_ready=1 after release.
REQ-039 Random stores against a memory model -> mem_rd and mem_wr never both high; final memory matches byte-wise reference model.
